mpmc9_strm_read_fetch: RTL and testbench

Client-side controller for the streaming read cache, operating in the cache's read clock domain.
- Accepts 128-bit line read requests from a stream client and drives the cache read address.
- Evaluates hit after the cache's two-register read pipeline.
- On a miss, issues a multi-line fill request to the memory port and re-looks-up once the fill completes.
- Sits between a streaming master (video/audio DMA) and the cache plus the MPMC fill engine.

---
 rtl/mpmc9_strm_read_fetch.sv | 183 ++++++++++++++++++
 tb/tb_mpmc9_strm_read_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc9_strm_read_fetch.sv
// rtl/mpmc9_strm_read_fetch.sv - streaming read-cache client fetch controller
//
// Purpose:
//   Accepts 128-bit line read requests from a stream client (video/audio
//   DMA) in the cache read clock domain, drives the cache read address,
//   evaluates hit after the cache's two-register read pipeline and, on a
//   miss, asks the MPMC fill engine for FILL_LINES consecutive lines before
//   re-running the lookup. After RETRY_MAX unsuccessful fills the request
//   is completed with err_o set.
//
// Ports:
//   rclk, rst          cache read clock, synchronous active-high reset
//   cs_i, adr_i        client request (held until ack_o) and byte address
//   ack_o              one-cycle completion pulse; dat_o / err_o valid
//   dat_o, err_o       returned line, retry-exhaustion flag
//   cache_radr_o       registered line-aligned cache read address
//   cache_rdat_i       cache line data (two-register pipeline behind radr)
//   cache_hit_i        cache hit flag, aligned with cache_rdat_i
//   fill_req_o         fill request, held until fill_ack_i
//   fill_adr_o         line-aligned fill start address
//   fill_len_o         fill line count (FILL_LINES)
//   fill_ack_i         fill engine accepted the request
//   fill_done_i        one-cycle pulse: all fill lines are in the cache

module mpmc9_strm_read_fetch #(
  parameter int FILL_LINES = 4,
  parameter int RETRY_MAX  = 3
) (
  input  logic         rclk,
  input  logic         rst,
  input  logic         cs_i,
  input  logic [31:0]  adr_i,
  output logic         ack_o,
  output logic [127:0] dat_o,
  output logic         err_o,
  output logic [31:0]  cache_radr_o,
  input  logic [127:0] cache_rdat_i,
  input  logic         cache_hit_i,
  output logic         fill_req_o,
  output logic [31:0]  fill_adr_o,
  output logic [3:0]   fill_len_o,
  input  logic         fill_ack_i,
  input  logic         fill_done_i
);

  // Retry counter must be able to hold RETRY_MAX itself.
  localparam int            RW        = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [2:0] {
    IDLE,
    W1,
    W2,
    CHK,
    FREQ,
    FWAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] retry_cnt;
  logic          cancel;
  logic          abandon;
  logic          can_retry;

  // The fill engine is told the line count once; it never changes.
  assign fill_len_o = 4'(FILL_LINES);

  // Client has gone away if cs_i was seen low at any edge since the
  // request was accepted, or is low right now.
  assign abandon   = cancel | ~cs_i;
  assign can_retry = (retry_cnt < RETRY_LIM);

  // A cancelled request still walks to DONE so that any fill handshake in
  // flight finishes cleanly, but the completion pulse is swallowed.
  assign ack_o = (state == DONE) && !cancel;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cs_i) begin
          state_next = W1;
        end
      end
      // The cache registers cache_radr_o during W1 and presents tag/data
      // during W2, so the hit decision can only be taken in CHK.
      W1:  state_next = W2;
      W2:  state_next = CHK;
      CHK: begin
        // A cancelled client gets no new fill; only an outstanding one is
        // allowed to finish.
        if (cache_hit_i || abandon || !can_retry) begin
          state_next = DONE;
        end else begin
          state_next = FREQ;
        end
      end
      FREQ: begin
        // A fill engine that accepts and completes in the same cycle skips
        // FWAIT entirely.
        if (fill_ack_i) begin
          state_next = fill_done_i ? W1 : FWAIT;
        end
      end
      FWAIT: begin
        if (fill_done_i) begin
          state_next = W1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and handshake registers
  // ---------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (rst) begin
      cache_radr_o <= '0;
      fill_adr_o   <= '0;
      fill_req_o   <= 1'b0;
      dat_o        <= '0;
      err_o        <= 1'b0;
      retry_cnt    <= '0;
      cancel       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // The only place the read address moves; it stays put across
          // every fill/re-lookup of this request.
          if (cs_i) begin
            cache_radr_o <= {adr_i[31:4], 4'h0};
            retry_cnt    <= '0;
            cancel       <= 1'b0;
          end
        end
        CHK: begin
          cancel <= abandon;
          if (cache_hit_i) begin
            dat_o <= cache_rdat_i;
            err_o <= 1'b0;
          end else if (!abandon && can_retry) begin
            fill_adr_o <= cache_radr_o;
            fill_req_o <= 1'b1;
            retry_cnt  <= retry_cnt + RW'(1);
          end else begin
            dat_o <= '0;
            err_o <= 1'b1;
          end
        end
        FREQ: begin
          cancel <= abandon;
          if (fill_ack_i) begin
            fill_req_o <= 1'b0;
          end
        end
        W1, W2, FWAIT: begin
          cancel <= abandon;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpmc9_strm_read_fetch.sv
// tb/tb_mpmc9_strm_read_fetch.sv - self-checking bench for mpmc9_strm_read_fetch

module tb_mpmc9_strm_read_fetch;

  localparam int FILL_LINES = 4;
  localparam int RETRY_MAX  = 3;

  logic         rclk = 1'b0;
  logic         rst;
  logic         cs_i;
  logic [31:0]  adr_i;
  logic         ack_o;
  logic [127:0] dat_o;
  logic         err_o;
  logic [31:0]  cache_radr_o;
  logic [127:0] cache_rdat_i = '0;
  logic         cache_hit_i = 1'b0;
  logic         fill_req_o;
  logic [31:0]  fill_adr_o;
  logic [3:0]   fill_len_o;
  logic         fill_ack_i;
  logic         fill_done_i;

  int checks = 0;
  int errors = 0;

  mpmc9_strm_read_fetch #(
    .FILL_LINES(FILL_LINES),
    .RETRY_MAX (RETRY_MAX)
  ) dut (
    .rclk        (rclk),
    .rst         (rst),
    .cs_i        (cs_i),
    .adr_i       (adr_i),
    .ack_o       (ack_o),
    .dat_o       (dat_o),
    .err_o       (err_o),
    .cache_radr_o(cache_radr_o),
    .cache_rdat_i(cache_rdat_i),
    .cache_hit_i (cache_hit_i),
    .fill_req_o  (fill_req_o),
    .fill_adr_o  (fill_adr_o),
    .fill_len_o  (fill_len_o),
    .fill_ack_i  (fill_ack_i),
    .fill_done_i (fill_done_i)
  );

  always #5 rclk = ~rclk;

  // Line content written by the fill engine: a fixed function of line index.
  function automatic logic [127:0] pat(input logic [27:0] ln);
    return {ln, 4'h0, ~ln, 4'hF, ln ^ 28'h5A5A5A5, 4'h3, 32'hC0DE0000 | 32'(ln[15:0])};
  endfunction

  // Cache model: two-register read pipeline behind cache_radr_o.
  logic [127:0] cmem [logic [27:0]];
  logic [31:0]  rq = '0;
  always @(posedge rclk) begin
    rq <= cache_radr_o;
    if (cmem.exists(rq[31:4])) begin
      cache_hit_i  <= 1'b1;
      cache_rdat_i <= cmem[rq[31:4]];
    end else begin
      cache_hit_i  <= 1'b0;
      cache_rdat_i <= {4{32'hDEADBEEF}};
    end
  end

  // Fill engine model.
  bit          fe_en = 1'b1;
  bit          fe_write = 1'b1;
  int          fe_ack_dly = 1;
  int          fe_done_dly = 1;
  int          fill_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_fill_adr = '0;
  logic [3:0]  last_fill_len = '0;
  logic        fe_ack = 1'b0;
  logic        fe_done = 1'b0;
  logic        man_done = 1'b0;

  assign fill_ack_i  = fe_ack;
  assign fill_done_i = fe_done | man_done;

  initial begin
    forever begin
      @(posedge rclk); #1;
      if (fe_en && fill_req_o) begin
        repeat (fe_ack_dly) begin @(posedge rclk); #1; end
        fe_ack        = 1'b1;
        fill_cnt++;
        last_fill_adr = fill_adr_o;
        last_fill_len = fill_len_o;
        if (fe_write) begin
          for (int k = 0; k < FILL_LINES; k++) begin
            logic [27:0] l;
            l = fill_adr_o[31:4] + 28'(k);
            cmem[l] = pat(l);
          end
        end
        if (fe_done_dly == 0) begin
          fe_done = 1'b1;
          @(posedge rclk); #1;
          fe_ack  = 1'b0;
          fe_done = 1'b0;
        end else begin
          @(posedge rclk); #1;
          fe_ack = 1'b0;
          repeat (fe_done_dly - 1) begin @(posedge rclk); #1; end
          fe_done = 1'b1;
          @(posedge rclk); #1;
          fe_done = 1'b0;
        end
        done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge rclk); #2;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issues one request, returns the completion data and the cycle count
  // from the cs_i sampling edge to the ack_o cycle.
  task automatic do_req(input logic [31:0] a, output logic [127:0] d, output logic e,
                        output int lat);
    bit ok;
    cs_i  = 1'b1;
    adr_i = a;
    lat   = 0;
    ok    = 1'b0;
    while (!ok && lat < 300) begin
      tick();
      lat++;
      if (ack_o) ok = 1'b1;
    end
    chk("ack_seen", ok, 1);
    d     = dat_o;
    e     = err_o;
    cs_i  = 1'b0;
    adr_i = $urandom;
    tick();
    chk("ack_pulse_width", ack_o, 0);
  endtask

  typedef struct {
    logic [31:0]  addr;
    bit           pre;
    logic [127:0] pre_dat;
    bit           fe_write;
    int           ack_dly;
    int           done_dly;
    logic [127:0] exp_dat;
    bit           exp_err;
    int           exp_fills;
    bit           chk_lat;
  } vec_t;

  vec_t         vt [9];
  logic [127:0] d;
  logic         e;
  int           lat;
  int           f0;
  int           dn0;
  int           n;
  bit           saw_ack;
  bit           saw_req;
  bit           model_valid [logic [27:0]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    cs_i  = 1'b0;
    adr_i = '0;
    repeat (3) tick();
    chk("rst_ack", ack_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_fill_req", fill_req_o, 0);
    chk("rst_fill_adr", fill_adr_o, 0);
    chk("rst_radr", cache_radr_o, 0);
    chk("fill_len", fill_len_o, FILL_LINES);
    rst = 1'b0;
    tick();

    // addr, pre, pre_dat, fe_write, ack_dly, done_dly, exp_dat, exp_err, exp_fills, chk_lat
    vt[0] = '{32'h0000_1234, 1'b1, {16{8'hA5}}, 1'b1, 1, 1, {16{8'hA5}}, 1'b0, 0, 1'b1};
    vt[1] = '{32'h0004_0010, 1'b0, 128'h0, 1'b1, 2, 3, pat(28'h0004001), 1'b0, 1, 1'b0};
    vt[2] = '{32'h0004_0020, 1'b0, 128'h0, 1'b1, 1, 1, pat(28'h0004002), 1'b0, 0, 1'b1};
    vt[3] = '{32'h0004_0030, 1'b0, 128'h0, 1'b1, 1, 1, pat(28'h0004003), 1'b0, 0, 1'b1};
    vt[4] = '{32'h0004_0040, 1'b0, 128'h0, 1'b1, 1, 1, pat(28'h0004004), 1'b0, 0, 1'b1};
    vt[5] = '{32'h0008_0000, 1'b0, 128'h0, 1'b0, 1, 2, 128'h0, 1'b1, RETRY_MAX, 1'b0};
    vt[6] = '{32'h0009_0000, 1'b0, 128'h0, 1'b1, 0, 0, pat(28'h0009000), 1'b0, 1, 1'b0};
    vt[7] = '{32'hFFFF_FFF8, 1'b0, 128'h0, 1'b1, 1, 2, pat(28'hFFFFFFF), 1'b0, 1, 1'b0};
    vt[8] = '{32'h0000_0005, 1'b0, 128'h0, 1'b1, 1, 1, pat(28'h0000000), 1'b0, 0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      if (vt[i].pre) cmem[vt[i].addr[31:4]] = vt[i].pre_dat;
      fe_write    = vt[i].fe_write;
      fe_ack_dly  = vt[i].ack_dly;
      fe_done_dly = vt[i].done_dly;
      f0 = fill_cnt;
      do_req(vt[i].addr, d, e, lat);
      chk($sformatf("v%0d_dat", i), d, vt[i].exp_dat);
      chk($sformatf("v%0d_err", i), e, vt[i].exp_err);
      chk($sformatf("v%0d_fills", i), fill_cnt - f0, vt[i].exp_fills);
      if (vt[i].chk_lat) chk($sformatf("v%0d_lat", i), lat, 4);
      if (vt[i].exp_fills > 0) begin
        chk($sformatf("v%0d_fill_adr", i), last_fill_adr, {vt[i].addr[31:4], 4'h0});
        chk($sformatf("v%0d_fill_len", i), last_fill_len, FILL_LINES);
      end
    end

    // Cancel during FWAIT: outstanding fill finishes, no ack, then IDLE.
    fe_write = 1'b1; fe_ack_dly = 1; fe_done_dly = 6;
    f0 = fill_cnt; dn0 = done_cnt;
    cs_i = 1'b1; adr_i = 32'h0030_0044;
    n = 0;
    while (!fill_ack_i && n < 50) begin tick(); n++; end
    chk("cancel_ack_seen", fill_ack_i, 1);
    tick();
    cs_i = 1'b0;
    saw_ack = 1'b0;
    repeat (40) begin tick(); saw_ack |= ack_o; end
    chk("cancel_no_ack", saw_ack, 0);
    chk("cancel_fills", fill_cnt - f0, 1);
    chk("cancel_done", done_cnt - dn0, 1);
    do_req(32'h0030_0058, d, e, lat);
    chk("cancel_next_dat", d, pat(28'h0030005));
    chk("cancel_next_lat", lat, 4);

    // Reset while a fill request is pending; a late fill_done_i is ignored.
    fe_en = 1'b0;
    cs_i = 1'b1; adr_i = 32'h0020_0000;
    n = 0;
    while (!fill_req_o && n < 20) begin tick(); n++; end
    chk("rstmid_req_seen", fill_req_o, 1);
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    cs_i = 1'b0;
    chk("rstmid_fill_req", fill_req_o, 0);
    chk("rstmid_ack", ack_o, 0);
    chk("rstmid_radr", cache_radr_o, 0);
    chk("rstmid_fill_adr", fill_adr_o, 0);
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    saw_ack = 1'b0; saw_req = 1'b0;
    repeat (10) begin tick(); saw_ack |= ack_o; saw_req |= fill_req_o; end
    chk("rstmid_late_done_ack", saw_ack, 0);
    chk("rstmid_late_done_req", saw_req, 0);
    fe_en = 1'b1;
    do_req(32'h0000_1238, d, e, lat);
    chk("rstmid_next_dat", d, {16{8'hA5}});
    chk("rstmid_next_lat", lat, 4);

    // Randomized requests against the line-validity reference model.
    cmem.delete();
    model_valid.delete();
    for (int i = 0; i < 16; i++) begin
      logic [27:0] l;
      l = 28'h0010000 + 28'($urandom_range(0, 63));
      cmem[l] = pat(l);
      model_valid[l] = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      logic [27:0]  l;
      logic [127:0] xd;
      bit           xe;
      int           xf;
      bit           xhit;
      l = 28'h0010000 + 28'($urandom_range(0, 63));
      fe_write    = ($urandom_range(0, 3) != 0);
      fe_ack_dly  = $urandom_range(0, 3);
      fe_done_dly = $urandom_range(0, 4);
      xhit = model_valid.exists(l);
      if (xhit) begin
        xd = pat(l); xe = 1'b0; xf = 0;
      end else if (fe_write) begin
        xd = pat(l); xe = 1'b0; xf = 1;
        for (int k = 0; k < FILL_LINES; k++) model_valid[l + 28'(k)] = 1'b1;
      end else begin
        xd = '0; xe = 1'b1; xf = RETRY_MAX;
      end
      f0 = fill_cnt;
      do_req({l, 4'($urandom)}, d, e, lat);
      chk($sformatf("rnd%0d_dat", i), d, xd);
      chk($sformatf("rnd%0d_err", i), e, xe);
      chk($sformatf("rnd%0d_fills", i), fill_cnt - f0, xf);
      if (xhit) chk($sformatf("rnd%0d_lat", i), lat, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
